// File: rtl/cam_frame_buf_ctrl.sv
// Frame-buffer write controller: queues packed camera words in a small FIFO and
// writes them into one of three rotating DDR buffers, publishing only complete frames.
module cam_frame_buf_ctrl #(
  parameter int                ADDR_W          = 28,
  parameter logic [ADDR_W-1:0] FRAME_BASE      = 28'h0,
  parameter logic [ADDR_W-1:0] FRAME_STRIDE    = 28'h0100000,
  parameter int                WORDS_PER_FRAME = 28800,
  parameter int                FIFO_DEPTH      = 8
) (
  input  logic              camera_pclk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              camera_vsync,
  input  logic              wr_valid,
  input  logic [255:0]      wr_data,
  output logic              ddr_wr_req,
  output logic [ADDR_W-1:0] ddr_wr_addr,
  output logic [255:0]      ddr_wr_data,
  input  logic              ddr_wr_ack,
  input  logic [1:0]        disp_busy_buf,
  output logic [1:0]        disp_buf,
  output logic              frame_done,
  output logic              frame_err,
  output logic              fifo_ovf
);

  localparam int DATA_W = 256;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(WORDS_PER_FRAME + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_VS,
    S_CAPTURE,
    S_DRAIN,
    S_COMMIT
  } state_t;

  state_t            state_q;
  logic              vs_q;
  logic [1:0]        wr_buf_q;
  logic [1:0]        wr_buf_d;
  logic [CNT_W-1:0]  in_cnt_q;
  logic [CNT_W-1:0]  out_cnt_q;
  logic              bad_q;
  logic              ovf_q;
  logic [1:0]        disp_buf_q;
  logic              done_q;
  logic              err_q;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W:0]    count_q;

  logic              vs_rise;
  logic              vs_fall;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              room;
  logic              in_cap;
  logic              at_limit;
  logic              push;
  logic              drop_full;
  logic              drop_limit;
  logic [ADDR_W-1:0] buf_off;
  logic [ADDR_W-1:0] word_off;

  assign vs_rise    = camera_vsync & ~vs_q;
  assign vs_fall    = ~camera_vsync & vs_q;
  assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = ddr_wr_req & ddr_wr_ack;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a word.
  assign room       = ~fifo_full | pop;
  assign in_cap     = (state_q == S_CAPTURE) & wr_valid;
  assign at_limit   = (in_cnt_q == CNT_W'(WORDS_PER_FRAME));
  assign push       = in_cap & ~at_limit & room;
  assign drop_full  = in_cap & ~at_limit & ~room;
  assign drop_limit = in_cap & at_limit;

  // Lowest buffer that is neither the published one nor the one being scanned.
  always_comb begin
    wr_buf_d = 2'd2;
    if (disp_buf_q != 2'd1 && disp_busy_buf != 2'd1) wr_buf_d = 2'd1;
    if (disp_buf_q != 2'd0 && disp_busy_buf != 2'd0) wr_buf_d = 2'd0;
  end

  always_comb begin
    buf_off = '0;
    case (wr_buf_q)
      2'd1:    buf_off = FRAME_STRIDE;
      2'd2:    buf_off = FRAME_STRIDE + FRAME_STRIDE;
      default: buf_off = '0;
    endcase
  end

  assign word_off    = ADDR_W'(out_cnt_q) << 5;
  assign ddr_wr_req  = ~fifo_empty;
  assign ddr_wr_addr = FRAME_BASE + buf_off + word_off;
  assign ddr_wr_data = ddr_wr_req ? mem_q[rd_ptr_q] : '0;

  assign disp_buf    = disp_buf_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;
  assign fifo_ovf    = ovf_q;

  always_ff @(posedge camera_pclk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge camera_pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge camera_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      vs_q       <= 1'b0;
      wr_buf_q   <= 2'd0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      bad_q      <= 1'b0;
      ovf_q      <= 1'b0;
      disp_buf_q <= 2'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      vs_q   <= camera_vsync;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (push) in_cnt_q  <= in_cnt_q + CNT_W'(1);
      if (pop)  out_cnt_q <= out_cnt_q + CNT_W'(1);
      if (drop_full) begin
        ovf_q <= 1'b1;
        bad_q <= 1'b1;
      end
      if (drop_limit) bad_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (init_done) state_q <= S_WAIT_VS;
        end
        S_WAIT_VS: begin
          if (vs_fall) begin
            wr_buf_q  <= wr_buf_d;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            ovf_q     <= 1'b0;
            bad_q     <= 1'b0;
            state_q   <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (vs_rise) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (fifo_empty) state_q <= S_COMMIT;
        end
        S_COMMIT: begin
          if (!bad_q && at_limit) begin
            disp_buf_q <= wr_buf_q;
            done_q     <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
          state_q <= S_WAIT_VS;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_frame_buf_ctrl.sv
// Randomized bench for cam_frame_buf_ctrl: a queue-based model predicts every DDR
// write and each frame's commit outcome.
module tb_cam_frame_buf_ctrl;

  localparam int          ADDR_W = 28;
  localparam logic [27:0] BASE   = 28'h0A00000;
  localparam logic [27:0] STRIDE = 28'h0100000;
  localparam int          WPF    = 40;
  localparam int          DEPTH  = 8;

  logic         camera_pclk;
  logic         rst_n;
  logic         init_done;
  logic         camera_vsync;
  logic         wr_valid;
  logic [255:0] wr_data;
  logic         ddr_wr_req;
  logic [27:0]  ddr_wr_addr;
  logic [255:0] ddr_wr_data;
  logic         ddr_wr_ack;
  logic [1:0]   disp_busy_buf;
  logic [1:0]   disp_buf;
  logic         frame_done;
  logic         frame_err;
  logic         fifo_ovf;

  cam_frame_buf_ctrl #(
    .ADDR_W(ADDR_W),
    .FRAME_BASE(BASE),
    .FRAME_STRIDE(STRIDE),
    .WORDS_PER_FRAME(WPF),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .camera_pclk(camera_pclk),
    .rst_n(rst_n),
    .init_done(init_done),
    .camera_vsync(camera_vsync),
    .wr_valid(wr_valid),
    .wr_data(wr_data),
    .ddr_wr_req(ddr_wr_req),
    .ddr_wr_addr(ddr_wr_addr),
    .ddr_wr_data(ddr_wr_data),
    .ddr_wr_ack(ddr_wr_ack),
    .disp_busy_buf(disp_busy_buf),
    .disp_buf(disp_buf),
    .frame_done(frame_done),
    .frame_err(frame_err),
    .fifo_ovf(fifo_ovf)
  );

  initial camera_pclk = 1'b0;
  always #5 camera_pclk = ~camera_pclk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: expected DDR writes in order, plus per-frame bookkeeping.
  typedef struct packed {
    logic [27:0]  a;
    logic [255:0] d;
  } wr_t;

  wr_t        exp_q[$];
  int         m_in;
  bit         m_bad;
  bit         m_ovf;
  bit         m_pop;
  int         seen_frame;
  int         frame_id;
  bit         cap_open;
  logic [1:0] m_wrbuf;
  logic [1:0] m_disp;
  int         ack_mode;
  logic [27:0] a0;
  logic [255:0] d0;

  always @(posedge camera_pclk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_in       = 0;
      m_bad      = 0;
      m_ovf      = 0;
      seen_frame = frame_id;
    end else begin
      m_pop = (exp_q.size() > 0) && ddr_wr_ack;
      if (seen_frame != frame_id) begin
        seen_frame = frame_id;
        m_in       = 0;
        m_bad      = 0;
        m_ovf      = 0;
      end
      if (cap_open && wr_valid) begin
        if (m_in >= WPF) m_bad = 1;
        else if (exp_q.size() < DEPTH || m_pop) begin
          exp_q.push_back({BASE + STRIDE * 28'(m_wrbuf) + 28'(m_in) * 28'd32, wr_data});
          m_in++;
        end else begin
          m_bad = 1;
          m_ovf = 1;
        end
      end
      if (m_pop) void'(exp_q.pop_front());
    end
  end

  always @(negedge camera_pclk) begin
    if (rst_n) begin
      check_eq("req", ddr_wr_req, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        check_eq("addr", ddr_wr_addr, exp_q[0].a);
        check_eq("data", ddr_wr_data, exp_q[0].d);
      end
    end
  end

  initial begin
    ddr_wr_ack = 1'b0;
    forever begin
      @(posedge camera_pclk);
      #2;
      case (ack_mode)
        0:       ddr_wr_ack = 1'b1;
        1:       ddr_wr_ack = ($urandom_range(0, 3) != 0);
        default: ddr_wr_ack = 1'b0;
      endcase
    end
  end

  task automatic step();
    @(posedge camera_pclk);
    #1;
  endtask

  task automatic send_word();
    wr_valid = 1'b1;
    for (int i = 0; i < 8; i++) wr_data[32*i +: 32] = $urandom;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic send_words(input int n, input int max_gap);
    for (int k = 0; k < n; k++) begin
      send_word();
      repeat ($urandom_range(0, max_gap)) step();
    end
  endtask

  task automatic start_frame(input logic [1:0] busy);
    camera_vsync = 1'b1;
    step();
    send_word();
    repeat (3) step();
    disp_busy_buf = busy;
    for (int b = 2; b >= 0; b--)
      if (2'(b) != m_disp && 2'(b) != busy) m_wrbuf = 2'(b);
    frame_id++;
    camera_vsync = 1'b0;
    repeat (3) step();
    cap_open = 1'b1;
    check_eq("ovf_clr", fifo_ovf, 0);
  endtask

  task automatic end_frame(input bit with_word);
    bit ok;
    int n;
    camera_vsync = 1'b1;
    if (with_word) send_word();
    else step();
    cap_open = 1'b0;
    ok = !m_bad && (m_in == WPF);
    n = 0;
    do begin
      @(negedge camera_pclk);
      n++;
    end while (!(frame_done || frame_err) && n < 5000);
    check_eq("commit_seen", frame_done | frame_err, 1);
    check_eq("frame_done", frame_done, ok);
    check_eq("frame_err", frame_err, !ok);
    if (ok) m_disp = m_wrbuf;
    check_eq("disp_buf", disp_buf, m_disp);
    @(negedge camera_pclk);
    check_eq("pulse_end", frame_done | frame_err, 0);
  endtask

  initial begin
    rst_n = 1'b0; init_done = 1'b0; camera_vsync = 1'b1; wr_valid = 1'b0; wr_data = '0;
    disp_busy_buf = 2'd0; ack_mode = 0; cap_open = 1'b0; m_disp = 2'd0; m_wrbuf = 2'd0;
    frame_id = 0;
    #12;
    check_eq("rst_req", ddr_wr_req, 0);
    check_eq("rst_addr", ddr_wr_addr, BASE);
    check_eq("rst_data", ddr_wr_data, 0);
    check_eq("rst_disp", disp_buf, 0);
    check_eq("rst_done", frame_done, 0);
    check_eq("rst_err", frame_err, 0);
    check_eq("rst_ovf", fifo_ovf, 0);
    #1 rst_n = 1'b1;
    step();
    init_done = 1'b1;
    repeat (2) step();

    // nominal frame, final word coincides with vsync rise; buffer 1
    ack_mode = 1;
    start_frame(2'd0);
    send_words(WPF - 1, 3);
    ack_mode = 0;
    end_frame(1'b1);

    // rotation: disp 1, busy 0 -> buffer 2
    ack_mode = 1;
    start_frame(2'd0);
    send_words(WPF, 2);
    ack_mode = 0;
    end_frame(1'b0);

    // lock: disp 2, busy 2 -> buffer 0
    start_frame(2'd2);
    send_words(WPF, 1);
    end_frame(1'b0);

    // backpressure with overflow
    start_frame(2'd0);
    send_words(5, 2);
    ack_mode = 2;
    send_words(20, 0);
    repeat (300) step();
    check_eq("ovf_set", fifo_ovf, 1);
    check_eq("bp_req", ddr_wr_req, 1);
    ack_mode = 0;
    send_words(3, 1);
    end_frame(1'b0);
    check_eq("ovf_hold", fifo_ovf, 1);

    // short frame
    start_frame(2'd1);
    send_words(10, 2);
    end_frame(1'b0);

    // long frame
    ack_mode = 1;
    start_frame(2'd1);
    send_words(WPF + 1, 1);
    ack_mode = 0;
    end_frame(1'b0);

    // stalled request then enqueue+pop at full; disp 0, busy 1 -> buffer 2
    start_frame(2'd1);
    ack_mode = 2;
    send_word();
    a0 = ddr_wr_addr;
    d0 = ddr_wr_data;
    check_eq("stall_first_addr", ddr_wr_addr, BASE + STRIDE + STRIDE);
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("stall_addr", ddr_wr_addr, a0);
      check_eq("stall_data", ddr_wr_data, d0);
    end
    send_words(7, 0);
    ack_mode = 0;
    send_word();
    send_words(WPF - 9, 0);
    end_frame(1'b0);

    // reset mid-frame with three words queued
    start_frame(2'd0);
    ack_mode = 2;
    send_words(3, 0);
    check_eq("pre_rst_req", ddr_wr_req, 1);
    #1;
    rst_n = 1'b0; cap_open = 1'b0; m_disp = 2'd0; init_done = 1'b0;
    #1;
    check_eq("mid_rst_req", ddr_wr_req, 0);
    check_eq("mid_rst_addr", ddr_wr_addr, BASE);
    check_eq("mid_rst_data", ddr_wr_data, 0);
    check_eq("mid_rst_disp", disp_buf, 0);
    check_eq("mid_rst_ovf", fifo_ovf, 0);
    repeat (3) step();
    rst_n = 1'b1;
    ack_mode = 0;
    camera_vsync = 1'b1;
    repeat (3) step();
    camera_vsync = 1'b0;
    repeat (3) step();
    send_words(5, 1);
    check_eq("idle_req", ddr_wr_req, 0);
    init_done = 1'b1;
    repeat (2) step();
    start_frame(2'd0);
    send_words(WPF, 2);
    end_frame(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
